elevator_request_queue: RTL and testbench

Collects hall and car call-button presses for the elevator car and holds them as a pending-request vector until the car reports the floor as served. It sits directly upstream of the elevator car model: it drives the car's `queue_status`, `queue_empty` and `next_up_ndown` inputs and consumes the car's `current_floor` and a served strobe. A SCAN-style direction FSM decides the next travel direction from the pending requests relative to the car's current floor.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/call_sync_edge.sv | 30 +++
 rtl/elevator_request_queue.sv | 102 ++++++++++
 tb/tb_elevator_request_queue.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared elevator constants and the direction-state encoding used by the
// request queue and the car model.
package elevator_pkg;

  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } dir_state_t;

endpackage

// File: rtl/call_sync_edge.sv
// Per-bit 2-flop synchronizer followed by a history flop; flags one-cycle
// rising edges so a held button yields a single request.
module call_sync_edge #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1_reg;
  logic [WIDTH-1:0] s2_reg;
  logic [WIDTH-1:0] s3_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= din;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign rise = s2_reg & ~s3_reg;

endmodule

// File: rtl/elevator_request_queue.sv
// Pending call-request register with a SCAN-style direction recommender
// that feeds the elevator car model.
module elevator_request_queue
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  floor_served,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  queue_empty,
  output logic                  next_up_ndown
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_UP   = UP;
  localparam logic [1:0] ST_DOWN = DOWN;

  logic [NUM_FLOORS-1:0] rise;
  logic [NUM_FLOORS-1:0] clear_vec;
  logic [NUM_FLOORS-1:0] above_vec;
  logic [NUM_FLOORS-1:0] below_vec;
  logic [NUM_FLOORS-1:0] pending_reg;
  logic [NUM_FLOORS-1:0] pending_next;
  logic [1:0]            state_reg;
  logic [1:0]            state_next;
  logic                  dir_reg;
  logic                  dir_next;
  logic                  above;
  logic                  below;

  call_sync_edge #(.WIDTH(NUM_FLOORS)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (call_btn),
    .rise  (rise)
  );

  // Widened compare so an out-of-range current_floor never matches a floor.
  generate
    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_floor
      localparam logic [FLOOR_W:0] IDX = (FLOOR_W+1)'(gi);
      assign clear_vec[gi] = floor_served && ({1'b0, current_floor} == IDX);
      assign above_vec[gi] = pending_reg[gi] && (IDX > {1'b0, current_floor});
      assign below_vec[gi] = pending_reg[gi] && (IDX < {1'b0, current_floor});
    end
  endgenerate

  assign above = |above_vec;
  assign below = |below_vec;

  // Clear wins over a same-floor set: the car is already standing there.
  assign pending_next = (pending_reg | rise) & ~clear_vec;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_UP: begin
        if (above)      state_next = ST_UP;
        else if (below) state_next = ST_DOWN;
        else            state_next = ST_IDLE;
      end
      ST_DOWN: begin
        if (below)      state_next = ST_DOWN;
        else if (above) state_next = ST_UP;
        else            state_next = ST_IDLE;
      end
      default: begin
        if (above)      state_next = ST_UP;
        else if (below) state_next = ST_DOWN;
        else            state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    dir_next = dir_reg;
    if (state_next == ST_UP)        dir_next = 1'b1;
    else if (state_next == ST_DOWN) dir_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
      state_reg   <= ST_IDLE;
      dir_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      state_reg   <= state_next;
      dir_reg     <= dir_next;
    end
  end

  assign queue_status  = pending_reg;
  assign queue_empty   = ~|pending_reg;
  assign next_up_ndown = dir_reg;

endmodule

// File: tb/tb_elevator_request_queue.sv
// Randomized and directed bench for elevator_request_queue against a
// behavioural model of the request/direction rules.
module tb_elevator_request_queue;

  localparam int NF = 7;
  localparam int FW = 3;
  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_DOWN = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] call_btn = '0;
  logic [FW-1:0] current_floor = '0;
  logic          floor_served = 1'b0;
  logic [NF-1:0] queue_status;
  logic          queue_empty;
  logic          next_up_ndown;

  int total = 0;
  int bad   = 0;

  // Model state: button samples from the last three edges, requests, direction.
  bit [NF-1:0] hist [3];
  bit [NF-1:0] m_pend;
  int          m_state;
  bit          m_dir;

  elevator_request_queue #(.NUM_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_btn      (call_btn),
    .current_floor (current_floor),
    .floor_served  (floor_served),
    .queue_status  (queue_status),
    .queue_empty   (queue_empty),
    .next_up_ndown (next_up_ndown)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: predict from pre-edge inputs, then compare after the edge.
  task automatic tick();
    bit [NF-1:0] np;
    bit          above;
    bit          below;
    int          ns;
    int          cf;
    if (reset) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_pend  = '0;
      m_state = M_IDLE;
      m_dir   = 1'b0;
    end else begin
      cf = int'(current_floor);
      above = 1'b0;
      below = 1'b0;
      for (int f = 0; f < NF; f++) begin
        if (m_pend[f] && f > cf) above = 1'b1;
        if (m_pend[f] && f < cf) below = 1'b1;
      end
      // A press sampled two edges ago that was low three edges ago.
      np = m_pend | (hist[1] & ~hist[2]);
      if (floor_served && cf < NF) np[cf] = 1'b0;
      case (m_state)
        M_UP:    ns = above ? M_UP : (below ? M_DOWN : M_IDLE);
        M_DOWN:  ns = below ? M_DOWN : (above ? M_UP : M_IDLE);
        default: ns = above ? M_UP : (below ? M_DOWN : M_IDLE);
      endcase
      if (ns == M_UP)   m_dir = 1'b1;
      if (ns == M_DOWN) m_dir = 1'b0;
      m_state = ns;
      m_pend  = np;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = call_btn;
    end
    @(posedge clk);
    #1;
    chk("queue_status", 32'(queue_status), 32'(m_pend));
    chk("queue_empty", 32'(queue_empty), 32'(m_pend == '0));
    chk("next_up_ndown", 32'(next_up_ndown), 32'(m_dir));
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset with floor 2 held through it.
    call_btn = 7'b0000100;
    do_reset(2);
    chk("rst_status", 32'(queue_status), 32'h0);
    chk("rst_empty", 32'(queue_empty), 32'h1);
    chk("rst_dir", 32'(next_up_ndown), 32'h0);
    repeat (2) tick();
    chk("held_rst_early", 32'(queue_status), 32'h0);
    tick();
    chk("held_rst_req", 32'(queue_status), 32'h04);

    // Single request from floor 1 to floor 5.
    call_btn = '0;
    do_reset(1);
    current_floor = 3'd1;
    call_btn = 7'b0100000;
    repeat (3) tick();
    chk("single_bit5", 32'(queue_status[5]), 32'h1);
    tick();
    chk("single_dir_up", 32'(next_up_ndown), 32'h1);
    call_btn = '0;
    current_floor = 3'd5;
    floor_served = 1'b1;
    tick();
    floor_served = 1'b0;
    chk("single_served", 32'(queue_status), 32'h0);
    chk("single_empty", 32'(queue_empty), 32'h1);
    tick();
    chk("single_dir_hold", 32'(next_up_ndown), 32'h1);

    // SCAN reversal: car at 3 with floors 0 and 6 pending.
    do_reset(1);
    current_floor = 3'd3;
    call_btn = 7'b1000001;
    repeat (4) tick();
    chk("scan_up", 32'(next_up_ndown), 32'h1);
    call_btn = '0;
    current_floor = 3'd6;
    floor_served = 1'b1;
    tick();
    floor_served = 1'b0;
    tick();
    chk("scan_down", 32'(next_up_ndown), 32'h0);
    chk("scan_left", 32'(queue_status), 32'h01);

    // Set and clear on the same floor: clear wins.
    do_reset(1);
    current_floor = 3'd2;
    call_btn = 7'b0000100;
    repeat (2) tick();
    floor_served = 1'b1;
    tick();
    floor_served = 1'b0;
    chk("same_floor_clear", 32'(queue_status[2]), 32'h0);
    // Set floor 4 while clearing floor 2.
    call_btn = '0;
    current_floor = 3'd0;
    repeat (2) tick();
    call_btn = 7'b0000100;
    repeat (3) tick();
    current_floor = 3'd2;
    call_btn = 7'b0010100;
    repeat (2) tick();
    floor_served = 1'b1;
    tick();
    floor_served = 1'b0;
    chk("diff_set4", 32'(queue_status[4]), 32'h1);
    chk("diff_clr2", 32'(queue_status[2]), 32'h0);

    // Held button: one request, served at cycle 20, never re-raised.
    call_btn = '0;
    do_reset(1);
    current_floor = 3'd0;
    call_btn = 7'b0001000;
    for (int c = 0; c < 50; c++) begin
      if (c == 20) begin
        current_floor = 3'd3;
        floor_served = 1'b1;
      end else begin
        floor_served = 1'b0;
      end
      tick();
    end
    chk("held_no_rereq", 32'(queue_status[3]), 32'h0);

    // Out-of-range floor: strobe must be ignored.
    call_btn = '0;
    do_reset(1);
    call_btn = 7'b1111111;
    repeat (3) tick();
    current_floor = 3'd7;
    floor_served = 1'b1;
    tick();
    floor_served = 1'b0;
    chk("boundary_keep", 32'(queue_status), 32'h7f);

    // Random traffic with occasional resets.
    call_btn = '0;
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      call_btn      = call_btn ^ NF'($urandom & $urandom & $urandom);
      current_floor = FW'($urandom_range(0, 7));
      floor_served  = ($urandom_range(0, 3) == 0);
      reset         = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    floor_served = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
